// File: rtl/sprite_pkg.sv
// Shared screen geometry, FSM encoding and slot helpers for the sprite drawing stage.
// Pure declarations: no latency, no flow control.
package sprite_pkg;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int NUM_PRESS_POS = 6;
    localparam int NUM_GARB_POS  = 4;

    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    // Press slots sweep right across columns 0..3 and then back to 1.
    function automatic logic [1:0] fold_col(input logic [2:0] pos);
        return (pos <= 3'd3) ? pos[1:0] : 2'(3'd6 - pos);
    endfunction

endpackage

// File: rtl/slot_mapper.sv
// Maps a slot request (item, position) to a sprite origin, extent and validity flag.
// Combinational, zero latency; it has no flow control of its own.
module slot_mapper
    import sprite_pkg::*;
#(
    parameter int COL_X0    = 16,
    parameter int COL_PITCH = 36,
    parameter int PRESS_Y   = 20,
    parameter int PRESS_W   = 24,
    parameter int PRESS_H   = 12,
    parameter int GARB_Y    = 90,
    parameter int GARB_W    = 16,
    parameter int GARB_H    = 12,
    parameter int CX_W      = 5,
    parameter int CY_W      = 4
) (
    input  logic            item,
    input  logic [2:0]      position,
    output logic            valid,
    output logic [7:0]      ox,
    output logic [6:0]      oy,
    output logic [CX_W-1:0] last_cx,
    output logic [CY_W-1:0] last_cy
);

    logic [1:0] col;
    logic [8:0] ox_sum;

    always_comb begin
        col    = item ? fold_col(position) : position[1:0];
        valid  = item ? (int'(position) < NUM_PRESS_POS) : (int'(position) < NUM_GARB_POS);
        ox_sum = 9'(COL_X0) + 9'(col) * 9'(COL_PITCH);
        // Garbage is narrower than the press and sits centred under it.
        if (!item) begin
            ox_sum = ox_sum + 9'((PRESS_W - GARB_W) / 2);
        end
        ox      = 8'(ox_sum);
        oy      = item ? 7'(PRESS_Y) : 7'(GARB_Y);
        last_cx = item ? CX_W'(PRESS_W - 1) : CX_W'(GARB_W - 1);
        last_cy = item ? CY_W'(PRESS_H - 1) : CY_W'(GARB_H - 1);
    end

endmodule

// File: rtl/sprite_plotter.sv
// Rasterises one press/garbage sprite per start handshake into a registered x/y/colour/plot stream.
// First pixel one cycle after start, done W*H+1 cycles after start (1 if invalid); start ignored while busy.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int         COL_X0       = 16,
    parameter int         COL_PITCH    = 36,
    parameter int         PRESS_Y      = 20,
    parameter int         PRESS_W      = 24,
    parameter int         PRESS_H      = 12,
    parameter int         GARB_Y       = 90,
    parameter int         GARB_W       = 16,
    parameter int         GARB_H       = 12,
    parameter logic [2:0] PRESS_COLOUR = 3'b111,
    parameter logic [2:0] GARB_COLOUR  = 3'b010
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       item,
    input  logic       erase,
    input  logic [2:0] position,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int CX_W = $clog2((PRESS_W > GARB_W) ? PRESS_W : GARB_W);
    localparam int CY_W = $clog2((PRESS_H > GARB_H) ? PRESS_H : GARB_H);

    if ((COL_X0 + 3 * COL_PITCH + PRESS_W > SCREEN_W) ||
        (PRESS_Y + PRESS_H > SCREEN_H) ||
        (GARB_Y + GARB_H > SCREEN_H)) begin : g_bad_geometry
        $error("sprite_plotter: sprite geometry falls outside the screen");
    end

    state_t          state, state_nxt;
    logic [CX_W-1:0] cx, cx_nxt, req_last_cx, last_cx_nxt;
    logic [CY_W-1:0] cy, cy_nxt, req_last_cy, last_cy_nxt;
    logic [7:0]      req_ox, ox_nxt, x_nxt;
    logic [6:0]      req_oy, oy_nxt, y_nxt;
    logic [2:0]      colour_nxt;
    logic            busy_nxt, done_nxt, plot_nxt;
    logic [8:0]      x_sum, y_sum;

    logic            map_valid;
    logic [7:0]      map_ox;
    logic [6:0]      map_oy;
    logic [CX_W-1:0] map_last_cx;
    logic [CY_W-1:0] map_last_cy;

    slot_mapper #(
        .COL_X0    (COL_X0),
        .COL_PITCH (COL_PITCH),
        .PRESS_Y   (PRESS_Y),
        .PRESS_W   (PRESS_W),
        .PRESS_H   (PRESS_H),
        .GARB_Y    (GARB_Y),
        .GARB_W    (GARB_W),
        .GARB_H    (GARB_H),
        .CX_W      (CX_W),
        .CY_W      (CY_W)
    ) u_slot_mapper (
        .item     (item),
        .position (position),
        .valid    (map_valid),
        .ox       (map_ox),
        .oy       (map_oy),
        .last_cx  (map_last_cx),
        .last_cy  (map_last_cy)
    );

    always_comb begin
        state_nxt   = state;
        cx_nxt      = cx;
        cy_nxt      = cy;
        ox_nxt      = req_ox;
        oy_nxt      = req_oy;
        last_cx_nxt = req_last_cx;
        last_cy_nxt = req_last_cy;
        colour_nxt  = colour;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        plot_nxt    = 1'b0;
        x_nxt       = x;
        y_nxt       = y;
        x_sum       = '0;
        y_sum       = '0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    // Geometry is captured from the mapper here so later input changes cannot disturb the draw.
                    busy_nxt    = 1'b1;
                    ox_nxt      = map_ox;
                    oy_nxt      = map_oy;
                    last_cx_nxt = map_last_cx;
                    last_cy_nxt = map_last_cy;
                    colour_nxt  = erase ? BLACK : (item ? PRESS_COLOUR : GARB_COLOUR);
                    cx_nxt      = '0;
                    cy_nxt      = '0;
                    if (map_valid) begin
                        state_nxt = DRAW;
                        plot_nxt  = 1'b1;
                        x_nxt     = map_ox;
                        y_nxt     = map_oy;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DRAW: begin
                if ((cx == req_last_cx) && (cy == req_last_cy)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    if (cx == req_last_cx) begin
                        cx_nxt = '0;
                        cy_nxt = cy + 1'b1;
                    end else begin
                        cx_nxt = cx + 1'b1;
                    end
                    plot_nxt = 1'b1;
                    x_sum    = 9'(req_ox) + 9'(cx_nxt);
                    y_sum    = 9'(req_oy) + 9'(cy_nxt);
                    x_nxt    = 8'(x_sum);
                    y_nxt    = 7'(y_sum);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            req_ox      <= '0;
            req_oy      <= '0;
            req_last_cx <= '0;
            req_last_cy <= '0;
            colour      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            plot        <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            state       <= state_nxt;
            cx          <= cx_nxt;
            cy          <= cy_nxt;
            req_ox      <= ox_nxt;
            req_oy      <= oy_nxt;
            req_last_cx <= last_cx_nxt;
            req_last_cy <= last_cy_nxt;
            colour      <= colour_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            plot        <= plot_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: expected pixels are queued per request and popped on each plot.
module tb_sprite_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       item     = 1'b0;
    logic       erase    = 1'b0;
    logic [2:0] position = 3'd0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int n_checks  = 0;
    int n_fail    = 0;
    int plot_cnt  = 0;
    int done_cnt  = 0;
    int below_cnt = 0;
    int x_floor   = 0;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t exp_q[$];

    sprite_plotter dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .item     (item),
        .erase    (erase),
        .position (position),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, req);
        end
    endtask

    function automatic int press_col(input int pos);
        case (pos)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic run_req(input bit it, input bit er, input int pos,
                           input int busy_at, input int reset_at, input string tag);
        bit valid;
        int ox, oy, w, h, c, exp_lat, lat, p0, d0, b0;
        valid = it ? (pos < 6) : (pos < 4);
        if (it) begin
            ox = valid ? 16 + 36 * press_col(pos) : 0;
            oy = 20; w = 24; h = 12;
            c  = er ? 0 : 7;
        end else begin
            ox = 20 + 36 * (pos % 4);
            oy = 90; w = 16; h = 12;
            c  = er ? 0 : 2;
        end
        if (valid) begin
            for (int cy = 0; cy < h; cy++)
                for (int cx = 0; cx < w; cx++)
                    exp_q.push_back('{ox + cx, oy + cy, c});
        end
        x_floor = valid ? ox : 0;
        p0 = plot_cnt; d0 = done_cnt; b0 = below_cnt;

        item = it; erase = er; position = 3'(pos); start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        item = 1'($urandom); erase = 1'($urandom); position = 3'($urandom);

        check_val({tag, "_busy_after_start"}, busy, 1);
        if (valid) begin
            check_val({tag, "_first_plot"}, plot, 1);
            check_val({tag, "_first_x"}, x, ox);
            check_val({tag, "_first_y"}, y, oy);
        end else begin
            check_val({tag, "_no_plot"}, plot, 0);
        end

        exp_lat = valid ? w * h + 1 : 1;
        lat = 1;
        while (!done && lat < 2000) begin
            if (lat == busy_at) begin
                start = 1'b1; item = 1'b1; position = 3'd0;
            end
            if (lat == busy_at + 1) start = 1'b0;
            if (lat == reset_at) begin
                reset = 1'b1;
                @(posedge CLOCK_50); #1;
                check_val({tag, "_rst_plot"}, plot, 0);
                check_val({tag, "_rst_busy"}, busy, 0);
                check_val({tag, "_rst_done"}, done, 0);
                check_val({tag, "_rst_x"}, x, 0);
                check_val({tag, "_rst_y"}, y, 0);
                reset = 1'b0;
                exp_q.delete();
                return;
            end
            @(posedge CLOCK_50); #1;
            lat++;
        end

        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_done_busy"}, busy, 1);
        check_val({tag, "_done_plot"}, plot, 0);
        @(posedge CLOCK_50); #1;
        check_val({tag, "_idle_busy"}, busy, 0);
        check_val({tag, "_idle_done"}, done, 0);
        check_val({tag, "_plot_count"}, plot_cnt - p0, valid ? w * h : 0);
        check_val({tag, "_done_pulses"}, done_cnt - d0, 1);
        check_val({tag, "_x_below_origin"}, below_cnt - b0, 0);
        check_val({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        fork
            forever begin
                pix_t e;
                @(negedge CLOCK_50);
                if (done) done_cnt++;
                if (plot) begin
                    plot_cnt++;
                    if (int'(x) < x_floor) below_cnt++;
                    if (exp_q.size() == 0) begin
                        check_val("extra_plot", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("pix_x", x, e.px);
                        check_val("pix_y", y, e.py);
                        check_val("pix_colour", colour, e.pc);
                    end
                end
            end
        join_none

        repeat (3) @(posedge CLOCK_50);
        #1;
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_plot", plot, 0);
        check_val("reset_x", x, 0);
        check_val("reset_y", y, 0);
        check_val("reset_colour", colour, 0);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;

        run_req(1'b1, 1'b0, 4, 0, 0, "press4");
        run_req(1'b0, 1'b1, 3, 0, 0, "garb_erase3");
        run_req(1'b0, 1'b0, 7, 0, 0, "garb_invalid7");
        run_req(1'b1, 1'b0, 6, 0, 0, "press_invalid6");
        run_req(1'b1, 1'b0, 4, 50, 0, "press_busy_start");
        run_req(1'b0, 1'b0, 1, 0, 100, "garb_reset");
        run_req(1'b0, 1'b0, 1, 0, 0, "garb_after_reset");
        for (int p = 0; p < 6; p++)
            run_req(1'b1, 1'b0, p, 0, 0, $sformatf("fold%0d", p));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Pixel-stream drawing stage between the game FSM and vga_adapter.
- Accepts one draw request per handshake: item (press/garbage), erase flag and slot position.
- Walks the sprite's bounding box in raster order and emits one x/y/colour/plot pixel per clock.
- Signals done when finished, so the game FSM waits on a handshake rather than a fixed delay count.

Parameters:
- COL_X0, 16, x origin of column 0
- COL_PITCH, 36, x distance between adjacent columns
- PRESS_Y, 20, top row of press sprite
- PRESS_W, 24, press width in pixels
- PRESS_H, 12, press height in pixels
- GARB_Y, 90, top row of garbage sprite
- GARB_W, 16, garbage width, centred in its column
- GARB_H, 12, garbage height
- PRESS_COLOUR, 3'b111, press RGB
- GARB_COLOUR, 3'b010, garbage RGB

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only when busy=0
- item  in  1  1=press sprite, 0=garbage sprite
- erase  in  1  1=draw in black (3'b000)
- position  in  3  slot: press 0..5, garbage 0..3
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- x  out  8  pixel x (0..159)
- y  out  7  pixel y (0..119)
- colour  out  3  pixel RGB
- plot  out  1  write enable to vga_adapter

Behaviour:
- One clock (CLOCK_50). Reset is synchronous and active-high.
- Reset values: busy=0, done=0, plot=0, x=0, y=0, colour=0, state=IDLE, internal counters 0.
- Reset mid-draw aborts immediately. Pixels already plotted stay on screen. No done pulse is issued.
- States:
  - IDLE: busy=0. On start=1, latch item/erase/position; go to DRAW if the request is valid, else go to DONE.
  - DRAW: one pixel per cycle.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Column mapping:
  - Press (item=1): position 0,1,2,3,4,5 maps to column 0,1,2,3,2,1. This is the back-and-forth fold.
  - Garbage (item=0): column = position[1:0].
- Invalid requests: press position 6/7 and any garbage position with position[2]=1 (3'b111 = no garbage). They go IDLE->DONE with zero plot cycles.
- Origin:
  - press ox = COL_X0 + col*COL_PITCH, oy = PRESS_Y
  - garbage ox = COL_X0 + col*COL_PITCH + (PRESS_W-GARB_W)/2, oy = GARB_Y
- Pixel order: cx runs 0..W-1 fastest, then cy 0..H-1. Output x = ox+cx, y = oy+cy.
- Outputs are registered. The first pixel (cx=0, cy=0) has plot=1 in the cycle after start is sampled.
- Exactly W*H consecutive plot cycles, with no gaps.
- done pulses in the cycle after the last plot. That cycle has plot=0.
- Start-to-done latency is W*H+1 cycles for a valid request and 1 cycle for an invalid one.
- colour = 3'b000 if erase, else PRESS_COLOUR or GARB_COLOUR. It is constant for the whole request.
- busy goes high the cycle after start is accepted and stays high through the done cycle.
- start while busy=1 is ignored. It is not queued.
- The earliest next start is sampled in the cycle after done (IDLE).
- Latched request fields are immune to input changes during DRAW.
- x and y hold their last values when plot=0.
- Width rules: cx is 5 bits and cy is 4 bits, sized from parameters with $clog2. Sums are computed at 9 bits and truncated to 8/7 bits.
- Elaboration assertion: COL_X0+3*COL_PITCH+PRESS_W <= 160, PRESS_Y+PRESS_H <= 120, GARB_Y+GARB_H <= 120.

Decomposition:
- Shared package (sprite_pkg):
  - screen constants SCREEN_W=160 and SCREEN_H=120
  - state encoding IDLE/DRAW/DONE
  - colour constants BLACK=3'b000
  - NUM_PRESS_POS=6, NUM_GARB_POS=4
- One natural sub-module: slot_mapper. It is combinational and does position/item to column fold, valid flag and origin (ox, oy, W, H).
- The FSM, raster counters and output registers stay in sprite_plotter.

Test Plan:
- Press draw: reset, then start with item=1, erase=0, position=4.
  - plot high for 288 cycles starting at x=88, y=20 (column 2), ending at x=111, y=31.
  - colour=3'b111 throughout; done pulses on cycle 289 after start.
- Garbage erase: item=0, erase=1, position=3.
  - 192 plots over x 128..143, y 90..101, colour=3'b000 throughout; done at cycle 193.
- Invalid request: item=0, position=3'b111.
  - zero plot cycles; busy=1 and done=1 in the cycle after start; busy=0 the following cycle.
- Start while busy: issue a second start with position=0 at cycle 50 of a press draw.
  - ignored: pixel count stays 288, one done pulse, x never drops below the first request's origin.
- Reset mid-draw: assert reset at cycle 100 of a garbage draw.
  - next cycle plot=0, busy=0, done=0, x=0, y=0.
  - a fresh start afterwards completes normally (192 plots).
- Fold sweep: press positions 0..5 back-to-back, each start issued the cycle after done.
  - first-pixel x = 16, 52, 88, 124, 88, 52.
